// File: rtl/krnl_partialknn_sp_loader_pkg.sv
// krnl_partialknn_sp_pkg
//   Shared types and constants for the partialKnn search-point buffer loader.
//   sp_state_e    : loader FSM states (IDLE, LOAD, DONE)
//   SP_DATA_WIDTH : buffer word width (memory d0/q0 width)
//   SP_DEPTH      : buffer depth in words
//   SP_ADDR_WIDTH : buffer address width, clog2(SP_DEPTH)
package krnl_partialknn_sp_pkg;
    localparam int SP_DATA_WIDTH = 256;
    localparam int SP_DEPTH      = 2048;
    localparam int SP_ADDR_WIDTH = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } sp_state_e;
endpackage

// File: rtl/krnl_partialknn_sp_loader_if.sv
// krnl_partialknn_sp_loader_if
//   Valid/ready search-point stream feeding the loader.
//   in_data  : payload word
//   in_valid : payload valid
//   in_last  : end-of-stream marker (checked only when last checking is built in)
//   in_ready : sink ready
//   modport master : stream producer
//   modport slave  : stream consumer (the loader)
interface krnl_partialknn_sp_loader_if
    import krnl_partialknn_sp_pkg::*;
#(
    parameter int DataWidth = SP_DATA_WIDTH
);
    logic [DataWidth-1:0] in_data;
    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;

    modport master (output in_data, output in_valid, output in_last, input in_ready);
    modport slave  (input in_data, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/krnl_partialknn_sp_loader.sv
// krnl_partialknn_sp_loader
//   Fill stage for the partialKnn local search-point buffer (single-port URAM).
//   Writes a stream of words sequentially from address 0, pulses done when the
//   requested count is written, and hands the memory port to the distance-compute
//   reader whenever it is idle.
// Ports
//   clk, reset      : clock, asynchronous active-low reset
//   start/num_words : load request, sampled in IDLE only; count clamps to AddressRange
//   sp_in           : search-point stream (slave side)
//   rd_en/rd_addr   : compute-stage read request, passed through while IDLE
//   rd_grant        : reader owns the memory port
//   busy            : load in progress (LOAD or DONE)
//   done            : one-cycle completion pulse
//   words_loaded    : words written in the current or last load
//   mem_*           : memory port 0 (address0, ce0, we0, d0)
//   last_err        : only with KRNL_PARTIALKNN_SP_LOADER_LAST_CHECK_EN defined;
//                     sticky flag for an in_last that disagrees with the count
// Build option
//   KRNL_PARTIALKNN_SP_LOADER_LAST_CHECK_EN : adds last_err and in_last checking.
module krnl_partialknn_sp_loader
    import krnl_partialknn_sp_pkg::*;
#(
    parameter int DataWidth    = SP_DATA_WIDTH,
    parameter int AddressRange = SP_DEPTH,
    parameter int AddressWidth = SP_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [AddressWidth:0]     num_words,
    krnl_partialknn_sp_loader_if.slave sp_in,
    input  logic                      rd_en,
    input  logic [AddressWidth-1:0]   rd_addr,
    output logic                      rd_grant,
    output logic                      busy,
    output logic                      done,
    output logic [AddressWidth:0]     words_loaded,
    output logic [AddressWidth-1:0]   mem_address0,
    output logic                      mem_ce0,
    output logic                      mem_we0,
    output logic [DataWidth-1:0]      mem_d0
`ifdef KRNL_PARTIALKNN_SP_LOADER_LAST_CHECK_EN
    ,
    output logic                      last_err
`endif
);
    localparam logic [AddressWidth:0] RANGE = AddressRange[AddressWidth:0];
    localparam logic [AddressWidth:0] ONE   = 1;

    sp_state_e             state_q, state_d;
    logic [AddressWidth:0] target_q;   // clamped word count for this load
    logic [AddressWidth:0] acc_q;      // beats accepted so far
    logic [AddressWidth:0] wl_q;       // words written so far, also next write address
    logic                  wr_vld_q;   // registered write strobe
    logic [DataWidth-1:0]  wr_data_q;
    logic                  start_ok;
    logic                  accept;

    assign start_ok       = (state_q == IDLE) && start;
    assign sp_in.in_ready = (state_q == LOAD) && (acc_q < target_q);
    assign accept         = sp_in.in_valid && sp_in.in_ready;

    always_comb begin
        state_d      = state_q;
        rd_grant     = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        mem_ce0      = wr_vld_q;
        mem_we0      = wr_vld_q;
        mem_address0 = wl_q[AddressWidth-1:0];
        unique case (state_q)
            IDLE: begin
                rd_grant     = 1'b1;
                busy         = 1'b0;
                mem_ce0      = rd_en;
                mem_we0      = 1'b0;
                mem_address0 = rd_addr;
                if (start) state_d = (num_words == '0) ? DONE : LOAD;
            end
            LOAD: begin
                // Leave only once the final word is actually on the memory port.
                if (wr_vld_q && ((wl_q + ONE) == target_q)) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign words_loaded = wl_q;
    assign mem_d0       = wr_data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            target_q  <= '0;
            acc_q     <= '0;
            wl_q      <= '0;
            wr_vld_q  <= 1'b0;
            wr_data_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_vld_q <= accept;
            if (accept) wr_data_q <= sp_in.in_data;
            if (start_ok) begin
                target_q <= (num_words > RANGE) ? RANGE : num_words;
                acc_q    <= '0;
                wl_q     <= '0;
            end else begin
                if (accept)   acc_q <= acc_q + ONE;
                if (wr_vld_q) wl_q  <= wl_q + ONE;
            end
        end
    end

`ifdef KRNL_PARTIALKNN_SP_LOADER_LAST_CHECK_EN
    // in_last must appear on exactly the final counted beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        last_err <= 1'b0;
        else if (start_ok) last_err <= 1'b0;
        else if (accept && (sp_in.in_last != (acc_q == (target_q - ONE))))
            last_err <= 1'b1;
    end
`else
    logic unused_last;
    assign unused_last = sp_in.in_last;
`endif
endmodule

// File: tb/tb_krnl_partialknn_sp_loader.sv
module tb_krnl_partialknn_sp_loader;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [11:0]  num_words = '0;
    logic         rd_en = 1'b0;
    logic [10:0]  rd_addr = '0;
    logic         rd_grant, busy, done, mem_ce0, mem_we0;
    logic [11:0]  words_loaded;
    logic [10:0]  mem_address0;
    logic [255:0] mem_d0;
`ifdef KRNL_PARTIALKNN_SP_LOADER_LAST_CHECK_EN
    logic         last_err;
`endif

    krnl_partialknn_sp_loader_if sp_if ();

    krnl_partialknn_sp_loader dut (
        .clk(clk), .reset(reset), .start(start), .num_words(num_words),
        .sp_in(sp_if), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_grant(rd_grant), .busy(busy), .done(done), .words_loaded(words_loaded),
        .mem_address0(mem_address0), .mem_ce0(mem_ce0), .mem_we0(mem_we0), .mem_d0(mem_d0)
`ifdef KRNL_PARTIALKNN_SP_LOADER_LAST_CHECK_EN
        , .last_err(last_err)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    logic [10:0]  wa_q[$];
    logic [255:0] wd_q[$];
    int           wc_q[$];
    int           dc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Write/done log, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we0) begin
            wa_q.push_back(mem_address0);
            wd_q.push_back(mem_d0);
            wc_q.push_back(cyc);
        end
        if (done) dc_q.push_back(cyc);
    end

    function automatic logic [255:0] dpat(input int i);
        logic [31:0] w;
        w = 32'hA500_0000 ^ i;
        return {8{w}};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr;
        wa_q.delete(); wd_q.delete(); wc_q.delete(); dc_q.delete();
    endtask

    task automatic do_start(input int n);
        num_words = n[11:0];
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) break;
            tick();
        end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL %s_done_timeout got %b want 1", nm, done); end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        tick(); tick();
        n_cmp++; if (rd_grant !== 1'b1) begin n_err++; $display("FAIL rst_grant got %b want 1", rd_grant); end
        n_cmp++; if ({busy, done, mem_ce0, mem_we0, sp_if.in_ready} !== 5'b0) begin n_err++; $display("FAIL rst_flags got %b want 00000", {busy, done, mem_ce0, mem_we0, sp_if.in_ready}); end
        n_cmp++; if (words_loaded !== 12'd0 || mem_address0 !== 11'd0 || mem_d0 !== '0) begin n_err++; $display("FAIL rst_vals got wl=%0d a=%0d want 0", words_loaded, mem_address0); end
`ifdef KRNL_PARTIALKNN_SP_LOADER_LAST_CHECK_EN
        n_cmp++; if (last_err !== 1'b0) begin n_err++; $display("FAIL rst_last_err got %b want 0", last_err); end
`endif
        reset = 1'b1;
        tick();
        n_cmp++; if (rd_grant !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL rst_idle got grant=%b busy=%b want 1 0", rd_grant, busy); end
    endtask

    task automatic test_back_to_back;
        clr();
        do_start(4);
        n_cmp++; if (busy !== 1'b1 || rd_grant !== 1'b0 || sp_if.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_load got busy=%b grant=%b rdy=%b want 1 0 1", busy, rd_grant, sp_if.in_ready); end
        for (int i = 0; i < 4; i++) begin
            sp_if.in_valid = 1'b1; sp_if.in_data = dpat(i);
            tick();
        end
        sp_if.in_valid = 1'b0;
        n_cmp++; if (sp_if.in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_rdy_after got %b want 0", sp_if.in_ready); end
        wait_done("b2b");
        n_cmp++; if (words_loaded !== 12'd4) begin n_err++; $display("FAIL b2b_words got %0d want 4", words_loaded); end
        tick();
        n_cmp++; if (rd_grant !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL b2b_grant got grant=%b done=%b want 1 0", rd_grant, done); end
        n_cmp++; if (wa_q.size() != 4) begin n_err++; $display("FAIL b2b_nwr got %0d want 4", wa_q.size()); end
        for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
            n_cmp++; if (wa_q[i] !== 11'(i) || wd_q[i] !== dpat(i) || wc_q[i] != wc_q[0] + i) begin n_err++; $display("FAIL b2b_wr%0d got a=%0d c=%0d want a=%0d c=%0d", i, wa_q[i], wc_q[i], i, wc_q[0] + i); end
        end
        n_cmp++; if (dc_q.size() != 1 || wc_q.size() != 4 || dc_q[0] != wc_q[3] + 1) begin n_err++; $display("FAIL b2b_done_cyc got n=%0d want 1 pulse one cycle after last write", dc_q.size()); end
    endtask

    task automatic test_gaps;
        clr();
        do_start(3);
        for (int j = 0; j < 5; j++) begin
            sp_if.in_valid = (j % 2 == 0); sp_if.in_data = dpat(10 + j);
            tick();
        end
        sp_if.in_valid = 1'b0;
        wait_done("gap");
        n_cmp++; if (words_loaded !== 12'd3) begin n_err++; $display("FAIL gap_words got %0d want 3", words_loaded); end
        tick();
        n_cmp++; if (wa_q.size() != 3) begin n_err++; $display("FAIL gap_nwr got %0d want 3", wa_q.size()); end
        for (int k = 0; k < 3 && k < wa_q.size(); k++) begin
            n_cmp++; if (wa_q[k] !== 11'(k) || wd_q[k] !== dpat(10 + 2 * k) || wc_q[k] != wc_q[0] + 2 * k) begin n_err++; $display("FAIL gap_wr%0d got a=%0d c=%0d want a=%0d c=%0d", k, wa_q[k], wc_q[k], k, wc_q[0] + 2 * k); end
        end
    endtask

    task automatic test_zero;
        clr();
        do_start(0);
        n_cmp++; if (done !== 1'b1 || busy !== 1'b1 || mem_we0 !== 1'b0) begin n_err++; $display("FAIL zero_done got done=%b busy=%b we=%b want 1 1 0", done, busy, mem_we0); end
        tick();
        n_cmp++; if (done !== 1'b0 || rd_grant !== 1'b1 || words_loaded !== 12'd0) begin n_err++; $display("FAIL zero_idle got done=%b grant=%b wl=%0d want 0 1 0", done, rd_grant, words_loaded); end
        n_cmp++; if (wa_q.size() != 0 || dc_q.size() != 1) begin n_err++; $display("FAIL zero_log got wr=%0d dn=%0d want 0 1", wa_q.size(), dc_q.size()); end
    endtask

    task automatic test_clamp;
        clr();
        do_start(4095);
        for (int i = 0; i < 2048; i++) begin
            sp_if.in_valid = 1'b1; sp_if.in_data = dpat(i);
            tick();
        end
        // keep offering beats past the clamped target
        n_cmp++; if (sp_if.in_ready !== 1'b0) begin n_err++; $display("FAIL clamp_rdy got %b want 0", sp_if.in_ready); end
        n_cmp++; if (mem_we0 !== 1'b1 || mem_address0 !== 11'd2047) begin n_err++; $display("FAIL clamp_lastwr got we=%b a=%0d want 1 2047", mem_we0, mem_address0); end
        tick();
        n_cmp++; if (done !== 1'b1 || words_loaded !== 12'd2048) begin n_err++; $display("FAIL clamp_done got done=%b wl=%0d want 1 2048", done, words_loaded); end
        sp_if.in_valid = 1'b0;
        tick();
        n_cmp++; if (wa_q.size() != 2048 || wa_q[wa_q.size() - 1] !== 11'd2047 || wd_q[wd_q.size() - 1] !== dpat(2047)) begin n_err++; $display("FAIL clamp_log got n=%0d want 2048 ending at 2047", wa_q.size()); end
    endtask

    task automatic test_rd_during_load;
        clr();
        num_words = 12'd2; start = 1'b1; rd_en = 1'b1; rd_addr = 11'd5;
        #1;
        n_cmp++; if (mem_ce0 !== 1'b1 || mem_we0 !== 1'b0 || mem_address0 !== 11'd5) begin n_err++; $display("FAIL rd_start got ce=%b we=%b a=%0d want 1 0 5", mem_ce0, mem_we0, mem_address0); end
        tick();
        start = 1'b0;
        sp_if.in_valid = 1'b1; sp_if.in_data = dpat(20);
        #1;
        n_cmp++; if (mem_ce0 !== 1'b0 || rd_grant !== 1'b0) begin n_err++; $display("FAIL rd_blocked got ce=%b grant=%b want 0 0", mem_ce0, rd_grant); end
        tick();
        sp_if.in_data = dpat(21);
        n_cmp++; if (mem_we0 !== 1'b1 || mem_address0 !== 11'd0) begin n_err++; $display("FAIL rd_wr0 got we=%b a=%0d want 1 0", mem_we0, mem_address0); end
        tick();
        sp_if.in_valid = 1'b0;
        n_cmp++; if (mem_we0 !== 1'b1 || mem_address0 !== 11'd1) begin n_err++; $display("FAIL rd_wr1 got we=%b a=%0d want 1 1", mem_we0, mem_address0); end
        wait_done("rd");
        tick();
        rd_addr = 11'd2;
        #1;
        n_cmp++; if (mem_ce0 !== 1'b1 || mem_we0 !== 1'b0 || mem_address0 !== 11'd2 || rd_grant !== 1'b1) begin n_err++; $display("FAIL rd_after got ce=%b we=%b a=%0d want 1 0 2", mem_ce0, mem_we0, mem_address0); end
        rd_en = 1'b0;
        n_cmp++; if (wa_q.size() != 2) begin n_err++; $display("FAIL rd_nwr got %0d want 2", wa_q.size()); end
    endtask

    task automatic test_reset_mid;
        clr();
        do_start(8);
        for (int i = 0; i < 2; i++) begin
            sp_if.in_valid = 1'b1; sp_if.in_data = dpat(30 + i);
            tick();
        end
        sp_if.in_valid = 1'b0;
        reset = 1'b0;
        #1;
        n_cmp++; if ({busy, done, mem_ce0, mem_we0, sp_if.in_ready} !== 5'b0 || rd_grant !== 1'b1 || words_loaded !== 12'd0) begin n_err++; $display("FAIL midrst_out got busy=%b done=%b we=%b grant=%b wl=%0d want 0 0 0 1 0", busy, done, mem_we0, rd_grant, words_loaded); end
        tick(); tick();
        reset = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if (dc_q.size() != 0 || busy !== 1'b0) begin n_err++; $display("FAIL midrst_nodone got pulses=%0d busy=%b want 0 0", dc_q.size(), busy); end
        clr();
        do_start(2);
        for (int i = 0; i < 2; i++) begin
            sp_if.in_valid = 1'b1; sp_if.in_data = dpat(40 + i);
            tick();
        end
        sp_if.in_valid = 1'b0;
        wait_done("midrst");
        tick();
        n_cmp++; if (wa_q.size() != 2 || wa_q[0] !== 11'd0 || wa_q[1] !== 11'd1 || wd_q[0] !== dpat(40)) begin n_err++; $display("FAIL midrst_reload got n=%0d want 2 writes at 0,1", wa_q.size()); end
    endtask

`ifdef KRNL_PARTIALKNN_SP_LOADER_LAST_CHECK_EN
    task automatic test_last_check;
        clr();
        do_start(4);
        for (int i = 0; i < 4; i++) begin
            sp_if.in_valid = 1'b1; sp_if.in_data = dpat(50 + i); sp_if.in_last = (i == 2);
            tick();
        end
        sp_if.in_valid = 1'b0; sp_if.in_last = 1'b0;
        wait_done("last_bad");
        n_cmp++; if (last_err !== 1'b1 || words_loaded !== 12'd4) begin n_err++; $display("FAIL last_bad got err=%b wl=%0d want 1 4", last_err, words_loaded); end
        tick();
        n_cmp++; if (wa_q.size() != 4) begin n_err++; $display("FAIL last_bad_nwr got %0d want 4", wa_q.size()); end
        do_start(4);
        n_cmp++; if (last_err !== 1'b0) begin n_err++; $display("FAIL last_clear got %b want 0", last_err); end
        for (int i = 0; i < 4; i++) begin
            sp_if.in_valid = 1'b1; sp_if.in_data = dpat(60 + i); sp_if.in_last = (i == 3);
            tick();
        end
        sp_if.in_valid = 1'b0; sp_if.in_last = 1'b0;
        wait_done("last_ok");
        n_cmp++; if (last_err !== 1'b0) begin n_err++; $display("FAIL last_ok got %b want 0", last_err); end
        tick();
    endtask
`endif

    initial begin
        sp_if.in_valid = 1'b0;
        sp_if.in_last  = 1'b0;
        sp_if.in_data  = '0;
        test_reset();
        test_back_to_back();
        test_gaps();
        test_zero();
        test_clamp();
        test_rd_during_load();
        test_reset_mid();
`ifdef KRNL_PARTIALKNN_SP_LOADER_LAST_CHECK_EN
        test_last_check();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
